unpack_fill_packet: RTL

UNPACK_FILL_PACKET -- requirements
Module: unpack_fill_packet

---
 rtl/unpack_fill_packet.sv | 134 +++++++++++++
 1 files changed

// File: rtl/unpack_fill_packet.sv
// Unpacks fixed-size packets of 64-bit words into header-delimited records,
// dropping tail fill and malformed headers and forwarding records through a ready/valid stage.
module unpack_fill_packet #(
    parameter int NUM            = 512,
    parameter int NUM_DATA_WIDTH = 10
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic        out_vld,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        pkt_done,
    output logic        err_len,
    output logic [15:0] rec_cnt
);
    localparam int W = NUM_DATA_WIDTH;
    localparam logic [W-1:0] LAST_IDX = W'(NUM - 1);
    localparam logic [W-1:0] ONE_W    = W'(1);
    localparam logic [W:0]   NUM_EXT  = (W + 1)'(NUM);
    localparam logic [63:0]  FILL     = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {S_HDR, S_BODY, S_SKIP} state_t;

    state_t      state_reg;
    logic [W-1:0] word_idx_reg;
    logic [W-1:0] remaining_reg;
    logic        out_vld_reg;
    logic [63:0] out_data_reg;
    logic        out_sop_reg;
    logic        out_eop_reg;
    logic        pkt_done_reg;
    logic        err_len_reg;
    logic [15:0] rec_cnt_reg;

    logic [W-1:0] hdr_len;
    logic [W:0]   len_sum;
    logic         is_fill;
    logic         hdr_bad;
    logic         is_last;
    logic         discard;
    logic         pop;
    logic         fwd;

    // The end-of-record sum is one bit wider so word_idx+L cannot wrap past NUM.
    assign hdr_len = fifo_dout[W-1:0];
    assign len_sum = {1'b0, word_idx_reg} + {1'b0, hdr_len};
    assign is_fill = (fifo_dout == FILL);
    assign hdr_bad = (hdr_len == '0) || (len_sum > NUM_EXT);
    assign is_last = (word_idx_reg == LAST_IDX);
    assign discard = (state_reg == S_SKIP) ||
                     ((state_reg == S_HDR) && (is_fill || hdr_bad));

    // Discarded words never need the output slot, so they drain even under backpressure.
    assign pop        = !fifo_empty && (discard || !out_vld_reg || out_ready);
    assign fwd        = pop && !discard;
    assign fifo_rd_en = pop && core_rst_n;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_reg     <= S_HDR;
            word_idx_reg  <= '0;
            remaining_reg <= '0;
            out_vld_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            pkt_done_reg  <= 1'b0;
            err_len_reg   <= 1'b0;
            rec_cnt_reg   <= '0;
        end else begin
            pkt_done_reg <= pop && is_last;
            err_len_reg  <= pop && (state_reg == S_HDR) && !is_fill && hdr_bad;

            if (out_vld_reg && out_ready) begin
                out_vld_reg <= 1'b0;
                if (out_eop_reg) begin
                    rec_cnt_reg <= rec_cnt_reg + 16'd1;
                end
            end

            if (pop) begin
                word_idx_reg <= is_last ? '0 : word_idx_reg + ONE_W;
                if (fwd) begin
                    out_vld_reg  <= 1'b1;
                    out_data_reg <= fifo_dout;
                end
                case (state_reg)
                    S_HDR: begin
                        if (is_fill || hdr_bad) begin
                            state_reg <= is_last ? S_HDR : S_SKIP;
                        end else begin
                            out_sop_reg <= 1'b1;
                            if (hdr_len == ONE_W) begin
                                out_eop_reg <= 1'b1;
                            end else begin
                                out_eop_reg   <= 1'b0;
                                remaining_reg <= hdr_len - ONE_W;
                                state_reg     <= S_BODY;
                            end
                        end
                    end
                    S_BODY: begin
                        out_sop_reg   <= 1'b0;
                        out_eop_reg   <= (remaining_reg == ONE_W);
                        remaining_reg <= remaining_reg - ONE_W;
                        if (remaining_reg == ONE_W) begin
                            state_reg <= S_HDR;
                        end
                    end
                    S_SKIP: begin
                        if (is_last) begin
                            state_reg <= S_HDR;
                        end
                    end
                    default: state_reg <= S_HDR;
                endcase
            end
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_data = out_data_reg;
    assign out_sop  = out_sop_reg;
    assign out_eop  = out_eop_reg;
    assign pkt_done = pkt_done_reg;
    assign err_len  = err_len_reg;
    assign rec_cnt  = rec_cnt_reg;

endmodule
